crc8_serial: RTL and testbench

CRC8_SERIAL -- requirements
Module: crc8_serial

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc8_step.sv | 32 +++
 rtl/xor_cell.sv | 11 +
 rtl/crc8_serial.sv | 79 +++++++
 tb/tb_crc8_serial.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC-8 engine: FSM state encoding and defaults.
// Imported by the top level; the step datapath is parameterised directly.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
   localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;
   localparam int         CNT_W             = 16;

endpackage

// File: rtl/crc8_step.sv
// One-bit MSB-first CRC-8 LFSR step built from XOR cells; purely combinational.
// Zero latency, no flow control: the caller decides when to register the result.
module crc8_step #(
   parameter logic [7:0] POLY = 8'h07
) (
   input  logic [7:0] crc_in,
   input  logic       bit_in,
   output logic [7:0] crc_next
);

   logic       fb;
   logic [7:0] shifted;
   logic [7:0] mask;

   xor_cell u_fb (
      .a (crc_in[7]),
      .b (bit_in),
      .y (fb)
   );

   assign shifted = {crc_in[6:0], 1'b0};
   assign mask    = fb ? POLY : 8'h00;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      xor_cell u_x (
         .a (shifted[i]),
         .b (mask[i]),
         .y (crc_next[i])
      );
   end

endmodule

// File: rtl/xor_cell.sv
// Two-input XOR gate cell; purely combinational building block.
// Zero latency, no flow control.
module xor_cell (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = a ^ b;

endmodule

// File: rtl/crc8_serial.sv
// Serial CRC-8 over an MSB-first bit stream; one bit per cycle, result one cycle after the last bit.
// bit_ready is high only in SHIFT; crc_valid is a single-cycle pulse with no backpressure.
module crc8_serial
   import crc_pkg::*;
#(
   parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
   parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             last,
   output logic             bit_ready,
   output logic             busy,
   output logic [7:0]       crc_out,
   output logic             crc_valid,
   output logic [CNT_W-1:0] bit_count
);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       crc;
   logic [7:0]       crc_step;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   assign accept = bit_valid && bit_ready;

   crc8_step #(
      .POLY (POLY)
   ) u_step (
      .crc_in   (crc),
      .bit_in   (bit_in),
      .crc_next (crc_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (accept && last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // crc and cnt are left untouched outside a frame so the last result stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= 8'h00;
         cnt <= '0;
      end else if (state == IDLE && start) begin
         crc <= INIT;
         cnt <= '0;
      end else if (accept) begin
         crc <= crc_step;
         if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bit_ready = (state == SHIFT);
   assign crc_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign crc_out   = crc;
   assign bit_count = cnt;

endmodule

// File: tb/tb_crc8_serial.sv
// Bench for crc8_serial: table-driven frames with a scoreboard queue, plus reset,
// start-during-frame, gapped-stream and counter-saturation sequences.
module tb_crc8_serial;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        bit_in;
   logic        bit_valid;
   logic        last;
   logic        bit_ready;
   logic        busy;
   logic [7:0]  crc_out;
   logic        crc_valid;
   logic [15:0] bit_count;

   int checks   = 0;
   int failures = 0;

   logic [23:0] exp_q[$];

   int          pulses = 0;
   int          dbl    = 0;
   logic        prev_v = 1'b0;
   logic [7:0]  cap_crc = 8'h00;
   logic [15:0] cap_cnt = 16'h0000;

   typedef struct {
      logic [15:0] data;
      int          nbits;
      logic [7:0]  crc;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[6];

   crc8_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .last      (last),
      .bit_ready (bit_ready),
      .busy      (busy),
      .crc_out   (crc_out),
      .crc_valid (crc_valid),
      .bit_count (bit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (crc_valid) begin
         pulses  <= pulses + 1;
         cap_crc <= crc_out;
         cap_cnt <= bit_count;
      end
      if (crc_valid && prev_v) dbl <= dbl + 1;
      prev_v <= crc_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one frame starting at a negedge; gap_mode idles every third cycle with last=1.
   task automatic send(input logic [71:0] data, input int nbits, input bit gap_mode,
                       input bit start_hold, input logic [7:0] exp_crc,
                       input logic [15:0] exp_cnt, input string name);
      int          i;
      int          cyc;
      int          n;
      int          base;
      logic [23:0] e;
      exp_q.push_back({exp_crc, exp_cnt});
      base = pulses;
      start = 1'b1;
      @(negedge clk);
      if (!start_hold) start = 1'b0;
      i   = 0;
      cyc = 0;
      while (i < nbits) begin
         if (gap_mode && (cyc % 3 == 2)) begin
            bit_valid = 1'b0;
            last      = 1'b1;
            bit_in    = 1'b1;
         end else begin
            bit_valid = 1'b1;
            bit_in    = (nbits - 1 - i < 72) ? data[nbits-1-i] : 1'b0;
            last      = (i == nbits - 1);
            i++;
         end
         cyc++;
         @(negedge clk);
      end
      bit_valid = 1'b0;
      last      = 1'b0;
      if (start_hold) begin
         check({name, "_done_busy"}, {31'd0, busy}, 32'd1);
         @(negedge clk);
         start = 1'b0;
         check({name, "_idle_after_done"}, {31'd0, busy}, 32'd0);
      end
      n = 0;
      #1;
      while (pulses == base && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      e = exp_q.pop_front();
      check({name, "_crc_valid_seen"}, pulses - base, 32'd1);
      check({name, "_crc"}, {24'd0, cap_crc}, {24'd0, e[23:16]});
      check({name, "_cnt"}, {16'd0, cap_cnt}, {16'd0, e[15:0]});
   endtask

   initial begin
      logic [3:0] part;
      int         p0;

      vecs[0] = '{data: 16'h0001, nbits: 8,  crc: 8'h07, cnt: 16'd8};
      vecs[1] = '{data: 16'h0080, nbits: 8,  crc: 8'h89, cnt: 16'd8};
      vecs[2] = '{data: 16'h0000, nbits: 8,  crc: 8'h00, cnt: 16'd8};
      vecs[3] = '{data: 16'h00FF, nbits: 8,  crc: 8'hF3, cnt: 16'd8};
      vecs[4] = '{data: 16'h0010, nbits: 8,  crc: 8'h70, cnt: 16'd8};
      vecs[5] = '{data: 16'h0100, nbits: 16, crc: 8'h15, cnt: 16'd16};

      rst_n     = 1'b0;
      start     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      last      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_crc_out",   {24'd0, crc_out},   32'd0);
      check("rst_bit_count", {16'd0, bit_count}, 32'd0);
      check("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("rst_bit_ready", {31'd0, bit_ready}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         send({56'd0, vecs[k].data}, vecs[k].nbits, 1'b0, 1'b0, vecs[k].crc, vecs[k].cnt,
              $sformatf("vec%0d", k));
         repeat (3) @(negedge clk);
         check($sformatf("vec%0d_hold_crc", k), {24'd0, crc_out}, {24'd0, vecs[k].crc});
         check($sformatf("vec%0d_hold_busy", k), {31'd0, busy}, 32'd0);
      end

      send(72'h313233343536373839, 72, 1'b1, 1'b0, 8'hF4, 16'd72, "check_str_gaps");
      @(negedge clk);

      send({64'd0, 8'h80}, 8, 1'b0, 1'b1, 8'h89, 16'd8, "start_held");
      @(negedge clk);

      // Reset mid-frame after four bits 1,0,0,0.
      p0    = pulses;
      part  = 4'b1000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("frame_ready", {31'd0, bit_ready}, 32'd1);
      check("frame_start_crc", {24'd0, crc_out}, 32'd0);
      for (int b = 0; b < 4; b++) begin
         bit_valid = 1'b1;
         bit_in    = part[3-b];
         @(negedge clk);
         if (b == 0) check("latency_1bit_crc", {24'd0, crc_out}, 32'h07);
      end
      bit_valid = 1'b0;
      check("partial_crc", {24'd0, crc_out}, 32'h38);
      check("partial_cnt", {16'd0, bit_count}, 32'd4);
      rst_n = 1'b0;
      #1;
      check("midrst_crc_out",   {24'd0, crc_out},   32'd0);
      check("midrst_busy",      {31'd0, busy},      32'd0);
      check("midrst_bit_count", {16'd0, bit_count}, 32'd0);
      check("midrst_bit_ready", {31'd0, bit_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_pulse", pulses - p0, 32'd0);
      send({64'd0, 8'h01}, 8, 1'b0, 1'b0, 8'h07, 16'd8, "after_rst");
      @(negedge clk);

      send(72'd0, 70000, 1'b0, 1'b0, 8'h00, 16'hFFFF, "saturate");
      @(negedge clk);

      check("single_cycle_pulses", dbl, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
